tpu_host_sequencer: RTL and testbench
=====================================

# tpu_host_sequencer

Host-side initiator for the 2x2 matrix-multiply accelerator's load/read port. It accepts a job as an 8-byte input stream (A0..A3, then B0..B3, row-major), drives the accelerator's load strobes, waits a fixed compute window, issues the four result reads, checks the accelerator's done pulse, and returns the four result low bytes on an output stream. It sits between the host byte-stream fabric and the accelerator controller.

## Interface
- WAIT_CYCLES, 10: cycles spent in COMPUTE between the last load strobe and the first read strobe; legal minimum 8.
- DONE_TIMEOUT, 4: CHECK cycles allowed for acc_done before flagging an error; legal minimum 1.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_valid / s_ready / s_data  in / out / in  1/1/8  job byte stream
- m_valid / m_ready / m_data / m_last  out / in / out / out  1/1/8/1  result stream, C0..C3
- acc_load_en / acc_load_sel_ab / acc_load_index / acc_load_data  out  1/1/2/8  load strobe; sel_ab 0=A, 1=B
- acc_output_en / acc_output_sel  out  1/2  read strobe and result index
- acc_out_data  in  8  result low byte, valid during the same cycle as acc_output_en
- acc_done  in  1  accelerator completion pulse
- busy  out  1  high whenever a job is in flight
- err  out  1  sticky done-timeout flag, cleared only by rst

## Operation
- States: LOAD (reset state), COMPUTE, READ, CHECK, DRAIN.
- LOAD: s_ready=1. Each accepted byte (s_valid&&s_ready) increments a 3-bit byte count and registers one load strobe. The strobe has acc_load_sel_ab=count[2], acc_load_index=count[1:0], and acc_load_data=s_data. The 8th byte moves the FSM to COMPUTE and clears the count.
- COMPUTE: s_ready=0. A down-counter holds the FSM here for exactly WAIT_CYCLES cycles, then moves it to READ.
- READ: 4 consecutive cycles with acc_output_en=1 and acc_output_sel=0,1,2,3. On each edge ending a READ cycle, acc_out_data is captured into buf[sel]. After sel 3, the FSM moves to CHECK.
- CHECK: acc_done=1 moves the FSM to DRAIN. Otherwise a counter runs; after DONE_TIMEOUT cycles without done, err is set and the FSM moves to DRAIN anyway.
- DRAIN: m_valid=1 and m_data=buf[idx], with m_last=1 when idx=3. idx advances on m_valid&&m_ready. The handshake with m_last returns the FSM to LOAD.
- busy = (state!=LOAD) || (byte count!=0).
- Arithmetic: results are truncated low bytes only; no width extension.

## Timing
- Reset values: s_ready=0 while rst is high and 1 from the first cycle after release. m_valid, m_data, m_last, all acc_* outputs, busy and err are 0. Buffers, counters and idx are cleared.
- Load latency: the byte accepted at edge k produces an acc_load_en pulse exactly one cycle wide, during the cycle following edge k. Back-to-back bytes give back-to-back strobes.
- s_valid gaps insert idle cycles with acc_load_en=0; the byte count holds.
- The 8th load strobe is asserted during the first COMPUTE cycle.
- The accelerator reaches its output window within 8 cycles of its last load; hence WAIT_CYCLES >= 8.
- acc_done is expected in the first CHECK cycle (the cycle after the 4th read strobe).
- Job latency with an ideal stream is 8 + WAIT_CYCLES + 4 + 1 cycles to the first m_valid.
- Backpressure: m_data and m_last are held stable while m_valid && !m_ready.
- s_valid is ignored outside LOAD.
- Reset mid-operation aborts the job immediately: all acc_* strobes drop asynchronously and the partial job is discarded.

## Configuration
- TPU_SEQ_DONE_CHECK_EN defined: CHECK state is present, acc_done is monitored, and err behaves as above.
- TPU_SEQ_DONE_CHECK_EN undefined: READ goes directly to DRAIN, acc_done is ignored, and err is tied 0. Latency drops by one cycle.

## Structure
- Shared package tpu_pkg holds:
  - the state enum (LOAD, COMPUTE, READ, CHECK, DRAIN);
  - JOB_BYTES=8 and RESULT_BYTES=4;
  - the A/B select encoding (SEL_A=0, SEL_B=1).
- One sub-module, tpu_result_buffer: 4x8 capture registers written by index, with a drain pointer, m_valid/m_ready handling and m_last generation.

## Test plan
- The bench uses a behavioral accelerator model computing C = A x B (2x2, row-major).
- Identity: A=1,2,3,4 and B=1,0,0,1 -> m_data 1,2,3,4; m_last on the 4th; err=0. Load strobes show sel_ab 0 with idx 0..3, then sel_ab 1 with idx 0..3.
- General: A=2,3,4,5 and B=6,7,8,9 -> m_data 36,41,64,73; first m_valid 23 cycles after the first byte edge (default WAIT_CYCLES).
- Truncation: all A and B bytes 255 -> every result 130050 (0x1FC02), so m_data is 0x02 four times.
- Backpressure: s_valid low for 2 cycles after byte 3, and m_ready low for 3 cycles on result 1 -> exactly 8 load strobes with no duplicates; m_data holds 41 stable; all 4 results delivered in order.
- Timeout: the model never asserts acc_done -> err=1 after 4 CHECK cycles and all 4 results still drain. With the macro undefined, err stays 0 and there are no CHECK cycles.
- Reset mid-COMPUTE: rst pulsed in the 3rd COMPUTE cycle -> all outputs 0 and s_ready=1 after release. A fresh job (A=2,3,4,5; B=6,7,8,9) then returns 36,41,64,73.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU host sequencer slice.
package tpu_pkg;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        COMPUTE = 3'd1,
        READ    = 3'd2,
        CHECK   = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam int JOB_BYTES    = 8;
    localparam int RESULT_BYTES = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Bytes 0..3 of a job are matrix A, bytes 4..7 are matrix B.
    function automatic logic sel_of_byte(input logic [2:0] byte_idx);
        return byte_idx[2] ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/tpu_host_sequencer_if.sv
// Host byte streams, accelerator load/read port and status for the host sequencer.
interface tpu_host_sequencer_if;

    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    logic       acc_load_en;
    logic       acc_load_sel_ab;
    logic [1:0] acc_load_index;
    logic [7:0] acc_load_data;
    logic       acc_output_en;
    logic [1:0] acc_output_sel;
    logic [7:0] acc_out_data;
    logic       acc_done;

    logic       busy;
    logic       err;

    modport master (
        input  s_valid, s_data, m_ready, acc_out_data, acc_done,
        output s_ready, m_valid, m_data, m_last,
               acc_load_en, acc_load_sel_ab, acc_load_index, acc_load_data,
               acc_output_en, acc_output_sel, busy, err
    );

    modport slave (
        output s_valid, s_data, m_ready, acc_out_data, acc_done,
        input  s_ready, m_valid, m_data, m_last,
               acc_load_en, acc_load_sel_ab, acc_load_index, acc_load_data,
               acc_output_en, acc_output_sel, busy, err
    );

endinterface

// File: rtl/tpu_result_buffer.sv
// Four result-byte capture registers plus the output-stream drain pointer.
module tpu_result_buffer
    import tpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  logic [1:0] wr_idx_i,
    input  logic [7:0] wr_data_i,
    input  logic       drain_en_i,
    input  logic       m_ready_i,
    output logic       m_valid_o,
    output logic [7:0] m_data_o,
    output logic       m_last_o,
    output logic       drain_done_o
);

    logic [7:0]              buf_q [RESULT_BYTES];
    logic [RESULT_BYTES-1:0] wr_sel;
    logic [1:0]              idx_q;
    logic                    handshake;

    generate
        for (genvar gi = 0; gi < RESULT_BYTES; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en_i && (wr_idx_i == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RESULT_BYTES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RESULT_BYTES; i++) begin
                if (wr_sel[i]) begin
                    buf_q[i] <= wr_data_i;
                end
            end
        end
    end

    assign handshake = drain_en_i && m_ready_i;

    // The pointer only moves on a completed handshake, so data/last hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (handshake) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    assign m_valid_o    = drain_en_i;
    assign m_data_o     = drain_en_i ? buf_q[idx_q] : 8'd0;
    assign m_last_o     = drain_en_i && (idx_q == 2'(RESULT_BYTES - 1));
    assign drain_done_o = handshake && (idx_q == 2'(RESULT_BYTES - 1));

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host-side job sequencer for the 2x2 matmul accelerator: load 8 bytes, wait, read 4 results, drain.
// Define TPU_SEQ_DONE_CHECK_EN to supervise acc_done with a sticky timeout flag (err).
module tpu_host_sequencer
    import tpu_pkg::*;
#(
    parameter int WAIT_CYCLES  = 10,
    parameter int DONE_TIMEOUT = 4
) (
    input logic                  clk,
    input logic                  rst,
    tpu_host_sequencer_if.master bus
);

    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]        rd_idx_q, rd_idx_d;
    logic              load_en_q, load_en_d;
    logic              load_sel_ab_q, load_sel_ab_d;
    logic [1:0]        load_index_q, load_index_d;
    logic [7:0]        load_data_q, load_data_d;

    logic accept;
    logic in_read;
    logic in_drain;
    logic drain_done;

`ifdef TPU_SEQ_DONE_CHECK_EN
    localparam int TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    assign accept   = bus.s_valid && bus.s_ready;
    assign in_read  = (state_q == READ);
    assign in_drain = (state_q == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD;
            byte_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            rd_idx_q      <= '0;
            load_en_q     <= 1'b0;
            load_sel_ab_q <= SEL_A;
            load_index_q  <= '0;
            load_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            rd_idx_q      <= rd_idx_d;
            load_en_q     <= load_en_d;
            load_sel_ab_q <= load_sel_ab_d;
            load_index_q  <= load_index_d;
            load_data_q   <= load_data_d;
        end
    end

`ifdef TPU_SEQ_DONE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        rd_idx_d      = rd_idx_q;
        load_en_d     = 1'b0;
        load_sel_ab_d = SEL_A;
        load_index_d  = '0;
        load_data_d   = '0;
`ifdef TPU_SEQ_DONE_CHECK_EN
        to_cnt_d      = to_cnt_q;
        err_d         = err_q;
`endif

        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    load_en_d     = 1'b1;
                    load_sel_ab_d = sel_of_byte(byte_cnt_q);
                    load_index_d  = byte_cnt_q[1:0];
                    load_data_d   = bus.s_data;
                    // The 3-bit count wraps to zero on the last job byte.
                    byte_cnt_d    = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'(JOB_BYTES - 1)) begin
                        state_d    = COMPUTE;
                        wait_cnt_d = WAIT_W'(WAIT_CYCLES - 1);
                    end
                end
            end

            COMPUTE: begin
                if (wait_cnt_q == '0) begin
                    state_d  = READ;
                    rd_idx_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end

            READ: begin
                rd_idx_d = rd_idx_q + 2'd1;
                if (rd_idx_q == 2'(RESULT_BYTES - 1)) begin
`ifdef TPU_SEQ_DONE_CHECK_EN
                    state_d  = CHECK;
                    to_cnt_d = '0;
`else
                    state_d  = DRAIN;
`endif
                end
            end

`ifdef TPU_SEQ_DONE_CHECK_EN
            CHECK: begin
                if (bus.acc_done) begin
                    state_d = DRAIN;
                end else if (to_cnt_q == TO_W'(DONE_TIMEOUT - 1)) begin
                    // Results are still drained so the host stream never stalls on a missing pulse.
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
`endif

            DRAIN: begin
                if (drain_done) begin
                    state_d = LOAD;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    tpu_result_buffer u_result_buffer (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (in_read),
        .wr_idx_i     (rd_idx_q),
        .wr_data_i    (bus.acc_out_data),
        .drain_en_i   (in_drain),
        .m_ready_i    (bus.m_ready),
        .m_valid_o    (bus.m_valid),
        .m_data_o     (bus.m_data),
        .m_last_o     (bus.m_last),
        .drain_done_o (drain_done)
    );

    // s_ready is gated by rst so it stays low for the whole reset pulse.
    assign bus.s_ready         = (state_q == LOAD) && !rst;
    assign bus.acc_load_en     = load_en_q;
    assign bus.acc_load_sel_ab = load_sel_ab_q;
    assign bus.acc_load_index  = load_index_q;
    assign bus.acc_load_data   = load_data_q;
    assign bus.acc_output_en   = in_read;
    assign bus.acc_output_sel  = rd_idx_q;
    assign bus.busy            = (state_q != LOAD) || (byte_cnt_q != 3'd0);

`ifdef TPU_SEQ_DONE_CHECK_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Directed bench for tpu_host_sequencer with a behavioural 2x2 matmul accelerator model.
module tb_tpu_host_sequencer;
    import tpu_pkg::*;

`ifdef TPU_SEQ_DONE_CHECK_EN
    localparam int  LAT      = 23;
    localparam int  TO_EXTRA = 3;
    localparam logic TO_ERR  = 1'b1;
`else
    localparam int  LAT      = 22;
    localparam int  TO_EXTRA = 0;
    localparam logic TO_ERR  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpu_host_sequencer_if bus ();

    tpu_host_sequencer #(
        .WAIT_CYCLES  (10),
        .DONE_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_strobes = 0;
    bit done_en = 1'b1;

    logic [7:0] ma [4];
    logic [7:0] mb [4];
    logic       done_q = 1'b0;

    // Accelerator model: captures load strobes, pulses done after the 4th read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.acc_load_en) begin
            if (bus.acc_load_sel_ab == SEL_B) mb[bus.acc_load_index] <= bus.acc_load_data;
            else                              ma[bus.acc_load_index] <= bus.acc_load_data;
            n_strobes <= n_strobes + 1;
        end
        done_q <= done_en && bus.acc_output_en && (bus.acc_output_sel == 2'd3);
    end

    assign bus.acc_done = done_q;

    always_comb begin
        int r;
        int k;
        int s;
        r = int'(bus.acc_output_sel[1]);
        k = int'(bus.acc_output_sel[0]);
        s = int'(ma[2*r]) * int'(mb[k]) + int'(ma[2*r+1]) * int'(mb[2+k]);
        bus.acc_out_data = s[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input string name, input logic [63:0] bytes, input int gap_after,
                           input int stall_idx, input logic [31:0] exp_c, input int exp_lat,
                           input logic exp_err);
        int base;
        int t0;
        int w;
        base = n_strobes;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = bytes[8*i +: 8];
            @(posedge clk); #1;
            check($sformatf("%s strobe%0d", name, i),
                  {bus.acc_load_en, bus.acc_load_sel_ab, bus.acc_load_index, bus.acc_load_data},
                  {1'b1, 3'(i), bytes[8*i +: 8]});
            if (i == gap_after) begin
                bus.s_valid = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                    check($sformatf("%s gap", name), {bus.acc_load_en, bus.busy}, 32'b01);
                end
            end
        end
        bus.s_valid = 1'b0;
        check($sformatf("%s compute", name), {bus.s_ready, bus.busy}, 32'b01);

        for (int r = 0; r < 4; r++) begin
            w = 0;
            @(negedge clk);
            while (bus.m_valid !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("%s m_valid%0d", name, r), bus.m_valid, 32'd1);
            if (r == 0) check($sformatf("%s latency", name), 32'(cyc - t0), 32'(exp_lat));
            if (r == stall_idx) begin
                bus.m_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check($sformatf("%s hold%0d", name, r), {bus.m_valid, bus.m_last, bus.m_data},
                          {1'b1, (r == 3), exp_c[8*r +: 8]});
                end
                bus.m_ready = 1'b1;
            end
            check($sformatf("%s C%0d", name, r), {bus.m_last, bus.m_data}, {(r == 3), exp_c[8*r +: 8]});
            $display("[TB] %s result %0d data=%0d last=%0b", name, r, bus.m_data, bus.m_last);
        end
        @(posedge clk); #1;
        check($sformatf("%s idle/err", name), {bus.busy, bus.err, bus.m_valid}, {1'b0, exp_err, 1'b0});
        check($sformatf("%s strobe count", name), 32'(n_strobes - base), 32'd8);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        bus.m_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state",
              {bus.s_ready, bus.busy, bus.err, bus.m_valid, bus.m_last, bus.m_data,
               bus.acc_load_en, bus.acc_load_data, bus.acc_output_en, bus.acc_output_sel},
              32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset release", {bus.s_ready, bus.busy, bus.acc_load_en}, 32'b100);
        @(posedge clk); #1;

        run_job("identity", 64'h01000001_04030201, -1, -1, 32'h04030201, LAT, 1'b0);
        run_job("general",  64'h09080706_05040302, -1, -1, 32'h49402924, LAT, 1'b0);
        run_job("trunc",    64'hFFFFFFFF_FFFFFFFF, -1, -1, 32'h02020202, LAT, 1'b0);
        run_job("backpres", 64'h09080706_05040302, 2, 1, 32'h49402924, LAT + 2, 1'b0);

        done_en = 1'b0;
        run_job("timeout",  64'h09080706_05040302, -1, -1, 32'h49402924, LAT + TO_EXTRA, TO_ERR);
        done_en = 1'b1;

        // Abort a job in its third COMPUTE cycle.
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i + 2);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("pre-abort busy", {bus.busy, bus.s_ready}, 32'b10);
        rst = 1'b1;
        #1;
        check("abort async",
              {bus.s_ready, bus.busy, bus.err, bus.m_valid, bus.m_last, bus.m_data,
               bus.acc_load_en, bus.acc_output_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort release", {bus.s_ready, bus.busy, bus.err, bus.acc_output_en, bus.m_valid}, 32'b10000);
        @(posedge clk); #1;

        run_job("fresh", 64'h09080706_05040302, -1, -1, 32'h49402924, LAT, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
